// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronized input, mid-bit sampling FSM,
// optional parity, 1 or 2 stop bits, and a one-word output buffer with overrun flag.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data_byte,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [15:0] CNT_FULL  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF  = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    logic [1:0]           sync_q, sync_d;
    state_e               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;

    logic rx_s;
    logic tick;
    logic done;
    logic hs;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == CNT_FULL);
    assign hs   = valid_q & i_data_ready;

    always_comb begin
        sync_d  = {sync_q[0], i_rx};
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    for (int k = 0; k < DATA_BITS; k++) begin
                        if (idx_q == 4'(k)) shift_d[k] = rx_s;
                    end
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    perr_d  = (PARITY == 1) ? ((^shift_q) == rx_s) : ((^shift_q) != rx_s);
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (!rx_s) ferr_d = 1'b1;
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Output buffer: a completed frame loads if the buffer is empty or being drained.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = ovr_q;
        busy_d     = (state_d != S_IDLE);

        if (done && (!valid_q || hs)) begin
            data_d     = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_d;
            valid_d    = 1'b1;
        end else if (hs) begin
            valid_d = 1'b0;
        end

        if (done && valid_q && !hs) begin
            ovr_d = 1'b1;
        end else if (hs) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign o_data_byte  = data_q;
    assign o_data_valid = valid_q;
    assign o_parity_err = perr_out_q;
    assign o_frame_err  = ferr_out_q;
    assign o_overrun    = ovr_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, directed cases plus
// randomized frames scored against a frame-level model.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0] d_a;
    logic [6:0] d_b;
    logic v_a, v_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b, bz_a, bz_b;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .i_rx(rx_a), .o_data_byte(d_a), .o_data_valid(v_a),
        .i_data_ready(rdy_a), .o_parity_err(pe_a), .o_frame_err(fe_a),
        .o_overrun(ov_a), .o_busy(bz_a));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .i_rx(rx_b), .o_data_byte(d_b), .o_data_valid(v_b),
        .i_data_ready(rdy_b), .o_parity_err(pe_b), .o_frame_err(fe_b),
        .o_overrun(ov_b), .o_busy(bz_b));

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   failures = 0;
    int   rise_a = 0;
    int   hi_a = 0;
    logic pv_a = 1'b0;
    bit   rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: what a correct receiver reports for the bits on the wire.
    function automatic exp_t model(input int ch, input logic [8:0] data, input logic pbit,
                                   input logic s1, input logic s2);
        exp_t e;
        int   nb = (ch == 0) ? 8 : 7;
        e.data = 9'(int'(data) % (1 << nb));
        if (ch == 0) begin
            e.perr = 1'b0;
            e.ferr = !s1;
        end else begin
            e.perr = ((^e.data) != pbit);
            e.ferr = !s1 || !s2;
        end
        return e;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bitout(input int ch, input logic b);
        if (ch == 0) rx_a = b; else rx_b = b;
        wait_cyc(CPB);
    endtask

    task automatic send(input int ch, input logic [8:0] data, input logic pbit,
                        input logic s1, input logic s2);
        int nb = (ch == 0) ? 8 : 7;
        bitout(ch, 1'b0);
        for (int i = 0; i < nb; i++) bitout(ch, data[i]);
        if (ch == 1) bitout(ch, pbit);
        bitout(ch, s1);
        if (ch == 1) bitout(ch, s2);
        if (ch == 0) rx_a = 1'b1; else rx_b = 1'b1;
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 3000) begin
            wait_cyc(1);
            t++;
        end
        chk("drain", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (v_a && !pv_a) rise_a++;
            if (v_a) hi_a++;
            if (v_a && rdy_a) begin
                if (qa.size() == 0) chk("a_unexpected", 32'd1, 32'd0);
                else begin
                    e = qa.pop_front();
                    chk("a_data", 32'(d_a), 32'(e.data));
                    chk("a_perr", 32'(pe_a), 32'(e.perr));
                    chk("a_ferr", 32'(fe_a), 32'(e.ferr));
                end
            end
            if (v_b && rdy_b) begin
                if (qb.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
                else begin
                    e = qb.pop_front();
                    chk("b_data", 32'(d_b), 32'(e.data));
                    chk("b_perr", 32'(pe_b), 32'(e.perr));
                    chk("b_ferr", 32'(fe_b), 32'(e.ferr));
                end
            end
        end
        pv_a = v_a;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) begin
                rdy_a = ($urandom_range(3) != 0);
                rdy_b = ($urandom_range(3) != 0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int         r0;
        logic [8:0] dat;
        logic       pb, s1, s2;

        // Reset state
        wait_cyc(4);
        @(negedge clk);
        chk("rst_a_data", 32'(d_a), 32'd0);
        chk("rst_a_valid", 32'(v_a), 32'd0);
        chk("rst_a_flags", 32'({pe_a, fe_a, ov_a, bz_a}), 32'd0);
        chk("rst_b_data", 32'(d_b), 32'd0);
        chk("rst_b_valid", 32'(v_b), 32'd0);
        chk("rst_b_flags", 32'({pe_b, fe_b, ov_b, bz_b}), 32'd0);
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(5);

        // 8N1 0xA5 with ready high: single-cycle valid
        rise_a = 0;
        hi_a   = 0;
        qa.push_back(model(0, 9'h0A5, 1'b0, 1'b1, 1'b1));
        send(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
        wait_cyc(10);
        chk("a5_rise", 32'(rise_a), 32'd1);
        chk("a5_hi_cycles", 32'(hi_a), 32'd1);
        chk("a5_consumed", 32'(qa.size()), 32'd0);

        // 7E2: 0x53 good parity, bad parity, then 0x3C with low second stop
        qb.push_back(model(1, 9'h053, 1'b0, 1'b1, 1'b1));
        send(1, 9'h053, 1'b0, 1'b1, 1'b1);
        wait_cyc(CPB);
        qb.push_back(model(1, 9'h053, 1'b1, 1'b1, 1'b1));
        send(1, 9'h053, 1'b1, 1'b1, 1'b1);
        wait_cyc(CPB);
        qb.push_back(model(1, 9'h03C, 1'b0, 1'b1, 1'b0));
        send(1, 9'h03C, 1'b0, 1'b1, 1'b0);
        wait_cyc(3 * CPB);
        chk("b_dir_consumed", 32'(qb.size()), 32'd0);

        // Overrun: second frame dropped while the first is still held
        rdy_a = 1'b0;
        qa.push_back(model(0, 9'h011, 1'b0, 1'b1, 1'b1));
        send(0, 9'h011, 1'b0, 1'b1, 1'b1);
        send(0, 9'h022, 1'b0, 1'b1, 1'b1);
        wait_cyc(5);
        @(negedge clk);
        chk("ovr_hold_data", 32'(d_a), 32'h11);
        chk("ovr_valid", 32'(v_a), 32'd1);
        chk("ovr_set", 32'(ov_a), 32'd1);
        wait_cyc(1);
        rdy_a = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        chk("ovr_cleared", 32'(ov_a), 32'd0);
        chk("ovr_valid_clr", 32'(v_a), 32'd0);
        wait_cyc(1);

        // Short low glitch on idle line
        r0 = rise_a;
        rx_a = 1'b0;
        wait_cyc(3);
        rx_a = 1'b1;
        wait_cyc(20);
        chk("glitch_idle", 32'(bz_a), 32'd0);
        chk("glitch_novalid", 32'(rise_a), 32'(r0));
        qa.push_back(model(0, 9'h0FF, 1'b0, 1'b1, 1'b1));
        send(0, 9'h0FF, 1'b0, 1'b1, 1'b1);
        drain();

        // Reset during data bit 4 abandons the frame
        r0 = rise_a;
        dat = 9'h096;
        bitout(0, 1'b0);
        for (int i = 0; i < 4; i++) bitout(0, dat[i]);
        rx_a = dat[4];
        wait_cyc(8);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        rx_a = 1'b1;
        wait_cyc(200);
        chk("rstmid_novalid", 32'(rise_a), 32'(r0));
        chk("rstmid_idle", 32'(bz_a), 32'd0);
        qa.push_back(model(0, 9'h05A, 1'b0, 1'b1, 1'b1));
        send(0, 9'h05A, 1'b0, 1'b1, 1'b1);
        drain();

        // Randomized frames on both channels with random ready
        rnd_rdy = 1'b1;
        fork
            begin
                for (int n = 0; n < 12; n++) begin
                    logic [8:0] d;
                    logic       st;
                    d  = 9'($urandom_range(255));
                    st = ($urandom_range(4) != 0);
                    qa.push_back(model(0, d, 1'b0, st, 1'b1));
                    send(0, d, 1'b0, st, 1'b1);
                    wait_cyc(st ? $urandom_range(20) : 3 * CPB);
                end
            end
            begin
                for (int n = 0; n < 12; n++) begin
                    logic [8:0] d;
                    d  = 9'($urandom_range(127));
                    pb = (^d) ^ ($urandom_range(3) == 0);
                    s1 = ($urandom_range(4) != 0);
                    s2 = ($urandom_range(4) != 0);
                    qb.push_back(model(1, d, pb, s1, s2));
                    send(1, d, pb, s1, s2);
                    wait_cyc(s2 ? $urandom_range(20) : 3 * CPB);
                end
            end
        join
        rnd_rdy = 1'b0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        drain();
        @(negedge clk);
        chk("rand_ovr_a", 32'(ov_a), 32'd0);
        chk("rand_ovr_b", 32'(ov_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 10417, meaning clk cycles per serial bit (legal range 4..65535).
REQ-002 The module SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-003 The module SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-004 The module SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (legal values 1 or 2).
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port i_rx, input, 1 bit: asynchronous serial line, idle high, LSB first.
REQ-008 Port o_data_byte, output, DATA_BITS wide: received data word.
REQ-009 Port o_data_valid, output, 1 bit: the held word and flags are valid.
REQ-010 Port i_data_ready, input, 1 bit: the consumer accepts the word.
REQ-011 Port o_parity_err, output, 1 bit: the held word failed its parity check.
REQ-012 Port o_frame_err, output, 1 bit: a stop bit of the held word sampled low.
REQ-013 Port o_overrun, output, 1 bit: sticky flag, a frame was dropped because the output was still full.
REQ-014 Port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 i_rx SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, and STOP, plus a 16-bit bit counter and a 4-bit bit index.
REQ-017 IDLE: the counter and index SHALL be cleared; a synchronized low SHALL move the FSM to START.
REQ-018 START: the counter SHALL increment until it equals (CLKS_PER_BIT-1)/2.
REQ-019 START, at the half-bit point: if the line is low, the counter SHALL clear and the FSM SHALL go to DATA; if high (glitch), the FSM SHALL return to IDLE with no output change.
REQ-020 DATA, PARITY, STOP: each bit SHALL be sampled when the counter reaches CLKS_PER_BIT-1 (one bit period after the previous sample), and the counter SHALL clear on each sample.
REQ-021 DATA: sample k SHALL be written to shift bit k; after DATA_BITS samples the FSM SHALL go to PARITY if PARITY != 0, else to STOP.
REQ-022 PARITY: the sampled bit SHALL be compared with the XOR of the data bits (even: XOR equals the parity bit; odd: XOR differs from it), and the FSM SHALL then go to STOP.
REQ-023 STOP: STOP_BITS samples SHALL be taken, and any low sample SHALL set the frame-error result.
REQ-024 STOP: after the last sample the FSM SHALL return to IDLE and the frame SHALL complete in that same cycle.
REQ-025 On frame completion with o_data_valid low: in the next cycle o_data_byte, o_parity_err, and o_frame_err SHALL load together and o_data_valid SHALL rise.
REQ-026 o_data_valid and the held values SHALL stay stable until a cycle with o_data_valid and i_data_ready both high; o_data_valid SHALL clear after that cycle.
REQ-027 On frame completion with o_data_valid high and no handshake in that cycle, the new frame SHALL be discarded and o_overrun SET.
REQ-028 Handshake in the same cycle as frame completion: the new frame SHALL load and o_data_valid SHALL stay high, with no overrun.
REQ-029 o_overrun SHALL clear only on a handshake cycle, unless that same cycle sets it.
REQ-030 The error flags SHALL be meaningful only while o_data_valid is high; o_parity_err SHALL be 0 when PARITY = 0.
REQ-031 Frames with a framing error SHALL still be delivered, with o_frame_err = 1.
REQ-032 A new start bit SHALL be detectable in the first IDLE cycle after STOP, so back-to-back frames are received.

Reset
REQ-033 While rst is high, both synchronizer flops SHALL be 1.
REQ-034 While rst is high, the FSM SHALL be IDLE and the counter and index SHALL be 0.
REQ-035 While rst is high, o_data_byte SHALL be 0 and o_data_valid, o_parity_err, o_frame_err, o_overrun, and o_busy SHALL all be 0.
REQ-036 rst asserted mid-frame SHALL abandon the frame with no output, and reception SHALL restart on the next start bit after release.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-037 Defaults (8N1), frame 0xA5, i_data_ready held high -> o_data_byte=0xA5, o_data_valid high for exactly 1 cycle, all error flags 0.
REQ-038 PARITY=2, DATA_BITS=7, 0x53 sent with a correct parity bit then with a wrong one -> o_parity_err=0 then 1, and o_data_byte=0x53 both times.
REQ-039 STOP_BITS=2, second stop bit driven low, data 0x3C -> o_data_byte=0x3C and o_frame_err=1.
REQ-040 i_data_ready low, frames 0x11 then 0x22 back-to-back -> o_data_byte stays 0x11 and o_overrun=1; raising i_data_ready -> o_overrun clears after the handshake.
REQ-041 Low pulse of 3 cycles on idle i_rx -> FSM returns to IDLE, o_data_valid stays 0, and the next valid frame 0xFF is received correctly.
REQ-042 rst pulsed at data bit 4 of a frame -> no o_data_valid; the following frame 0x5A is received correctly.
